serial_addsub_n: RTL and testbench
==================================

Name: serial_addsub_n

Overview:
Digit-serial two's-complement adder/subtractor. It generalises the single-bit serial adder (carry flip-flop "state", q = a^b^state) to a DIGIT_W-bit digit per cycle, a fixed word length, and a per-word add/sub mode. It also adds end-of-word carry-out and signed-overflow flags. It sits between digit-serial datapath stages, operands LSB-digit first.

Parameters:
DIGIT_W, 1, bits processed per cycle (>=1)
WORD_DIGITS, 8, digits per word (>=1); word width = DIGIT_W*WORD_DIGITS

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
in_valid  in  1  a/b/sof/sub carry a digit this cycle
sof  in  1  start of word; qualifies current digit as digit 0
sub  in  1  mode, sampled only on digit 0: 0 = a+b, 1 = a-b
a  in  DIGIT_W  operand A digit
b  in  DIGIT_W  operand B digit
q  out  DIGIT_W  registered result digit
q_valid  out  1  q holds a new digit (1-cycle pulse per digit)
eow  out  1  q is the last digit of a word; flags below valid
cout  out  1  word carry-out (sub: 1 = no borrow), valid with eow
ovf  out  1  signed overflow of the word, valid with eow
state  out  1  current carry register (carry into next digit)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. Reset values: q=0, q_valid=0, eow=0, cout=0, ovf=0, state=0, digit counter=0, latched mode=0 (and zero flag=1 if present).
- Digit-0 condition: d0 = in_valid & (sof | cnt==0).
- On d0, latch mode_r <= sub. The effective mode is m = d0 ? sub : mode_r.
- Arithmetic per valid digit:
  - b_eff = m ? ~b : b
  - cin = d0 ? m : state
  - sum = a + b_eff + cin, computed DIGIT_W+1 wide
  - q <= sum[DIGIT_W-1:0]; state <= sum[DIGIT_W]
- Latency: 1 cycle, digit in to q/q_valid.
- Counter: cnt <= (d0 ? 1 : cnt+1). It wraps to 0 after digit WORD_DIGITS-1. If WORD_DIGITS=1, every digit is digit 0 and the last digit.
- Last digit (position WORD_DIGITS-1):
  - eow <= 1
  - cout <= sum[DIGIT_W]
  - ovf <= carry into MSB ^ carry out of MSB, computed on the digit's top bit (a[MSB] ^ b_eff[MSB] ^ sum[MSB] gives carry-in to MSB)
  - state still updates, but is ignored by the next word because that word's digit 0 uses cin=m.
- in_valid=0:
  - cnt, state, mode_r hold
  - q_valid=0, eow=0
  - q, cout, ovf hold their last values
  - sof/sub/a/b ignored.
- sof while cnt!=0: the partial word is abandoned with no eow. The current digit becomes digit 0 and sub is re-sampled. Already-output digits of the abandoned word are not retracted.
- sof while cnt==0: same as an implicit word start.
- sub changing mid-word: ignored until the next digit 0.
- Reset mid-word: the partial word is discarded. The next valid digit is digit 0 regardless of sof.
- cout/ovf are only meaningful in the cycle eow=1. They may change only on eow cycles.

Optional Feature:
SERIAL_ADDSUB_ZFLAG_EN.
- Defined: adds output port zero (1 bit), valid with eow. It is 1 iff every result digit of the word was 0.
  - Internal accumulator: on d0 set to (sum digit==0); otherwise AND with (sum digit==0).
  - zero <= final value on the last digit.
  - zero holds otherwise; reset value is 1.
- Undefined: no zero port and no accumulator logic. All other behaviour is identical.

Test Plan:
- DIGIT_W=1, WORD_DIGITS=8, sub=0: a=0x5A, b=0x33 LSB-first, in_valid continuous -> q bits over 8 cycles = 0x8D, eow on 8th output, cout=0, ovf=1, state toggling as the carry chain dictates.
- Same config, sub=1: a=0x10, b=0x20 -> q=0xF0, cout=0 (borrow), ovf=0. Back-to-back next word a=0x33 b=0x33 sub=1 -> q=0x00, cout=1, ovf=0, zero=1 if ZFLAG_EN.
- DIGIT_W=4, WORD_DIGITS=2: 0x7F+0x01 -> q digits 0x0,0x8, cout=0, ovf=1. Then 0xFF+0x01 -> 0x00, cout=1, ovf=0.
- Gapped valid: same as first test with in_valid low every other cycle, and sub toggled during the gaps and mid-word -> identical q sequence and flags; q_valid only the cycle after each valid digit.
- Abort/restart: 3 digits of a word, then sof with a new word 0x01+0x01 (DIGIT_W=1) -> no eow for the aborted word; the new word gives q=0x02, eow after 8 digits, cout=0.
- Reset asserted after 4 digits, then a full word 0xFF+0x01 without sof -> all outputs 0 the cycle after reset; result q=0x00, cout=1, ovf=0.

Source files
------------

// File: rtl/serial_addsub_n.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first.
// Define SERIAL_ADDSUB_ZFLAG_EN to add the per-word zero flag output.
module serial_addsub_n #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               sof,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [DIGIT_W-1:0] q,
  output logic               q_valid,
  output logic               eow,
  output logic               cout,
  output logic               ovf,
`ifdef SERIAL_ADDSUB_ZFLAG_EN
  output logic               zero,
`endif
  output logic               state
);

  localparam int CW = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_DIGITS - 1);

  logic [CW-1:0]      r_cnt;
  logic               r_mode;
  logic               r_state;
  logic [DIGIT_W-1:0] r_q;
  logic               r_qv;
  logic               r_eow;
  logic               r_cout;
  logic               r_ovf;

  logic               w_d0;
  logic               w_m;
  logic               w_cin;
  logic               w_last;
  logic               w_cmsb;
  logic [DIGIT_W-1:0] w_beff;
  logic [DIGIT_W:0]   w_sum;
  logic [CW-1:0]      w_cnt_nx;

  always_comb begin
    w_d0   = in_valid & (sof | (r_cnt == '0));
    w_m    = w_d0 ? sub : r_mode;
    w_beff = w_m ? ~b : b;
    w_cin  = w_d0 ? w_m : r_state;
    w_sum  = {1'b0, a} + {1'b0, w_beff}
           + {{DIGIT_W{1'b0}}, w_cin};
    // A forced digit 0 is last only for one-digit words
    w_last = w_d0 ? (WORD_DIGITS == 1)
                  : (r_cnt == LAST);
    w_cmsb = a[DIGIT_W-1] ^ w_beff[DIGIT_W-1]
           ^ w_sum[DIGIT_W-1];
    if (w_last)
      w_cnt_nx = '0;
    else if (w_d0)
      w_cnt_nx = CW'(1);
    else
      w_cnt_nx = r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_state <= 1'b0;
      r_q     <= '0;
      r_qv    <= 1'b0;
      r_eow   <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (in_valid) begin
      r_cnt   <= w_cnt_nx;
      r_state <= w_sum[DIGIT_W];
      r_q     <= w_sum[DIGIT_W-1:0];
      r_qv    <= 1'b1;
      r_eow   <= w_last;
      if (w_d0)
        r_mode <= sub;
      if (w_last) begin
        r_cout <= w_sum[DIGIT_W];
        r_ovf  <= w_cmsb ^ w_sum[DIGIT_W];
      end
    end else begin
      r_qv  <= 1'b0;
      r_eow <= 1'b0;
    end
  end

`ifdef SERIAL_ADDSUB_ZFLAG_EN
  logic r_zacc;
  logic r_zero;
  logic w_zacc_nx;

  always_comb begin
    w_zacc_nx = (w_sum[DIGIT_W-1:0] == '0)
              & (w_d0 | r_zacc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zacc <= 1'b1;
      r_zero <= 1'b1;
    end else if (in_valid) begin
      r_zacc <= w_zacc_nx;
      if (w_last)
        r_zero <= w_zacc_nx;
    end
  end

  assign zero = r_zero;
`endif

  assign q       = r_q;
  assign q_valid = r_qv;
  assign eow     = r_eow;
  assign cout    = r_cout;
  assign ovf     = r_ovf;
  assign state   = r_state;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Bench for serial_addsub_n: a 1-bit x8 and a 4-bit x2 instance,
// word-level arithmetic model, directed words and random traffic.
module tb_serial_addsub_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       v0, s0, u0, v1, s1, u1;
  logic [0:0] a0, b0, q0;
  logic [3:0] a1, b1, q1;
  logic       qv0, e0, c0, o0, st0;
  logic       qv1, e1, c1, o1, st1;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
  logic       z0, z1;
`endif

  serial_addsub_n #(.DIGIT_W(1), .WORD_DIGITS(8)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(v0), .sof(s0),
    .sub(u0), .a(a0), .b(b0), .q(q0), .q_valid(qv0),
    .eow(e0), .cout(c0), .ovf(o0),
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    .zero(z0),
`endif
    .state(st0));

  serial_addsub_n #(.DIGIT_W(4), .WORD_DIGITS(2)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(v1), .sof(s1),
    .sub(u1), .a(a1), .b(b1), .q(q1), .q_valid(qv1),
    .eow(e1), .cout(c1), .ovf(o1),
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    .zero(z1),
`endif
    .state(st1));

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Word-level model: operands accumulate per word; each
  // output digit is a slice of A + (sub ? -B : B).
  longint mA[2], mB[2];
  int     mpos[2];
  bit     mmode[2];
  logic [3:0] eq[2];
  bit     eqv[2], eeow[2], ecout[2], eovf[2], est[2], ez[2];

  task automatic mstep(int i, int W, bit v, bit s, bit sb,
                       longint ad, longint bd);
    int N = 8 / W;
    int bits;
    longint mask, beff, sm, r;
    bit sa, sbb, sr;
    if (reset) begin
      eq[i] = 0; eqv[i] = 0; eeow[i] = 0; ecout[i] = 0;
      eovf[i] = 0; est[i] = 0; ez[i] = 1;
      mpos[i] = 0; mmode[i] = 0; mA[i] = 0; mB[i] = 0;
    end else if (!v) begin
      eqv[i] = 0; eeow[i] = 0;
    end else begin
      if (s || mpos[i] == 0) begin
        mmode[i] = sb; mpos[i] = 0; mA[i] = 0; mB[i] = 0;
      end
      mA[i] |= ad << (mpos[i] * W);
      mB[i] |= bd << (mpos[i] * W);
      bits = (mpos[i] + 1) * W;
      mask = (64'sd1 <<< bits) - 1;
      beff = mmode[i] ? (~mB[i] & mask) : mB[i];
      sm   = mA[i] + beff + longint'(mmode[i]);
      eq[i]  = 4'((sm >> (mpos[i] * W)) & ((1 << W) - 1));
      est[i] = bit'((sm >> bits) & 1);
      eqv[i] = 1;
      if (mpos[i] == N - 1) begin
        r   = sm & mask;
        sa  = bit'((mA[i] >> (bits - 1)) & 1);
        sbb = bit'((mB[i] >> (bits - 1)) & 1);
        sr  = bit'((r >> (bits - 1)) & 1);
        eeow[i]  = 1;
        ecout[i] = est[i];
        eovf[i]  = mmode[i] ? (sa != sbb && sr != sa)
                            : (sa == sbb && sr != sa);
        ez[i]    = (r == 0);
        mpos[i]  = 0;
      end else begin
        eeow[i] = 0;
        mpos[i]++;
      end
    end
  endtask

  always @(posedge clk) begin
    mstep(0, 1, v0, s0, u0, longint'(a0), longint'(b0));
    mstep(1, 4, v1, s1, u1, longint'(a1), longint'(b1));
  end

  // Collected words: {cout, ovf, word}
  logic [7:0] wq0, wq1;
  logic [9:0] hq0[$], hq1[$];

  always @(negedge clk) begin
    if (chk_on) begin
      chk("q_d1", q0, eq[0]);
      chk("qvalid_d1", qv0, eqv[0]);
      chk("eow_d1", e0, eeow[0]);
      chk("cout_d1", c0, ecout[0]);
      chk("ovf_d1", o0, eovf[0]);
      chk("state_d1", st0, est[0]);
      chk("q_d4", q1, eq[1]);
      chk("qvalid_d4", qv1, eqv[1]);
      chk("eow_d4", e1, eeow[1]);
      chk("cout_d4", c1, ecout[1]);
      chk("ovf_d4", o1, eovf[1]);
      chk("state_d4", st1, est[1]);
`ifdef SERIAL_ADDSUB_ZFLAG_EN
      chk("zero_d1", z0, ez[0]);
      chk("zero_d4", z1, ez[1]);
`endif
    end
    if (qv0) wq0 = {q0, wq0[7:1]};
    if (qv1) wq1 = {q1, wq1[7:4]};
    if (e0) hq0.push_back({c0, o0, wq0});
    if (e1) hq1.push_back({c1, o1, wq1});
  end

  task automatic idle();
    v0 = 0; v1 = 0;
    s0 = $urandom; u0 = $urandom; a0 = $urandom; b0 = $urandom;
    s1 = $urandom; u1 = $urandom; a1 = $urandom; b1 = $urandom;
  endtask

  task automatic drive(int i, bit s, bit sb, int ad, int bd);
    idle();
    if (i == 0) begin
      v0 = 1; s0 = s; u0 = sb; a0 = 1'(ad); b0 = 1'(bd);
    end else begin
      v1 = 1; s1 = s; u1 = sb; a1 = 4'(ad); b1 = 4'(bd);
    end
  endtask

  task automatic send(int i, logic [7:0] wa, logic [7:0] wb,
                      bit sb, bit gap, bit use_sof, int nd);
    int W = (i == 0) ? 1 : 4;
    int m = (1 << W) - 1;
    for (int k = 0; k < nd; k++) begin
      drive(i, use_sof && k == 0,
            (k == 0 || !gap) ? sb : bit'($urandom),
            int'(wa >> (k * W)) & m, int'(wb >> (k * W)) & m);
      @(negedge clk);
      if (gap) begin
        idle();
        @(negedge clk);
      end
    end
    idle();
  endtask

  task automatic expw(int i, string nm, logic [7:0] w,
                      bit c, bit o);
    logic [9:0] e;
    if (i == 0 ? hq0.size() == 0 : hq1.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s got=no_word exp=%0h", nm, w);
    end else begin
      e = (i == 0) ? hq0.pop_front() : hq1.pop_front();
      chk({nm, "_word"}, e[7:0], w);
      chk({nm, "_cout"}, e[9], c);
      chk({nm, "_ovf"}, e[8], o);
    end
  endtask

  task automatic noword(int i, string nm);
    chk(nm, (i == 0) ? hq0.size() : hq1.size(), 0);
  endtask

  initial begin
    reset = 1; idle();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    chk_on = 1;
    chk("rst_q", {q0, q1}, 0);
    chk("rst_flags", {qv0, e0, c0, o0, st0, qv1, e1, c1, o1, st1}, 0);

    send(0, 8'h5A, 8'h33, 0, 0, 1, 8);
    @(negedge clk);
    expw(0, "add5A33", 8'h8D, 0, 1);

    send(0, 8'h10, 8'h20, 1, 0, 1, 8);
    send(0, 8'h33, 8'h33, 1, 0, 1, 8);
    @(negedge clk);
    expw(0, "sub1020", 8'hF0, 0, 0);
    expw(0, "sub3333", 8'h00, 1, 0);
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    chk("zero3333", z0, 1);
`endif

    send(1, 8'h7F, 8'h01, 0, 0, 1, 2);
    send(1, 8'hFF, 8'h01, 0, 0, 1, 2);
    @(negedge clk);
    expw(1, "d4_7F01", 8'h80, 0, 1);
    expw(1, "d4_FF01", 8'h00, 1, 0);

    send(0, 8'h5A, 8'h33, 0, 1, 1, 8);
    @(negedge clk);
    expw(0, "gapped", 8'h8D, 0, 1);

    send(0, 8'hFF, 8'h00, 0, 0, 1, 3);
    send(0, 8'h01, 8'h01, 0, 0, 1, 8);
    @(negedge clk);
    expw(0, "restart", 8'h02, 0, 0);
    noword(0, "abort_noeow");

    send(0, 8'h55, 8'h0F, 1, 0, 1, 4);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_mid_out", {q0, qv0, e0, c0, o0, st0}, 0);
    send(0, 8'hFF, 8'h01, 0, 0, 0, 8);
    @(negedge clk);
    expw(0, "post_rst", 8'h00, 1, 0);
    noword(0, "rst_noeow");

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      v0 = ($urandom_range(0, 3) != 0);
      s0 = ($urandom_range(0, 9) == 0);
      u0 = $urandom; a0 = $urandom; b0 = $urandom;
      v1 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 5) == 0);
      u1 = $urandom; a1 = $urandom; b1 = $urandom;
      @(negedge clk);
    end
    reset = 0; idle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
